// File: rtl/video_timing_pkg.sv
// Shared types and helpers for the video timing blocks.
// The optional test-pattern build is selected with VTS_TEST_PATTERN_EN and
// uses the black/white constants and the grid helper below.
package video_timing_pkg;

    // Stream engine state: IDLE shows no pixels, RUN pulls pixels, DRAIN
    // finishes the current frame after enable has dropped.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fsm_e;

    localparam logic [23:0] RGB_BLACK = 24'h000000;
    localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;

    function automatic int htotal(input int hdisp, input int hfp, input int hpulse, input int hbp);
        return hdisp + hfp + hpulse + hbp;
    endfunction

    function automatic int vtotal(input int vdisp, input int vfp, input int vpulse, input int vbp);
        return vdisp + vfp + vpulse + vbp;
    endfunction

    // Width of a counter/coordinate covering 0..n-1, never less than 1 bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Grid lines every 16 pixels/lines, starting at the top-left pixel.
    function automatic logic grid_on(input int px, input int py);
        return ((px % 16) == 0) || ((py % 16) == 0);
    endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Free-running raster counters with sync, active-area and frame-end decode.
// Line/frame order is front porch, sync, back porch, active. Every output is
// a combinational decode of the counter registers; the consumer registers them.
module video_timing_counter
    import video_timing_pkg::*;
#(
    parameter int HDISP  = 800,
    parameter int VDISP  = 480,
    parameter int HFP    = 40,
    parameter int HPULSE = 48,
    parameter int HBP    = 40,
    parameter int VFP    = 12,
    parameter int VPULSE = 3,
    parameter int VBP    = 40,
    localparam int XW    = cnt_w(HDISP),
    localparam int YW    = cnt_w(VDISP)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_active,
    output logic          o_first,
    output logic          o_frame_end,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y
);

    localparam int HTOT   = htotal(HDISP, HFP, HPULSE, HBP);
    localparam int VTOT   = vtotal(VDISP, VFP, VPULSE, VBP);
    localparam int HCW    = cnt_w(HTOT);
    localparam int VCW    = cnt_w(VTOT);
    localparam int HSTART = HFP + HPULSE + HBP;
    localparam int VSTART = VFP + VPULSE + VBP;

    logic [HCW-1:0] r_h_cnt;
    logic [VCW-1:0] r_v_cnt;
    logic           w_h_last;
    logic           w_v_last;
    logic           w_h_active;
    logic           w_v_active;

    assign w_h_last   = (r_h_cnt == HCW'(HTOT - 1));
    assign w_v_last   = (r_v_cnt == VCW'(VTOT - 1));
    assign w_h_active = (r_h_cnt >= HCW'(HSTART));
    assign w_v_active = (r_v_cnt >= VCW'(VSTART));

    // Raster counters: h wraps every line, v steps on each h wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + VCW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + HCW'(1);
        end
    end

    assign o_hsync     = (r_h_cnt >= HCW'(HFP)) && (r_h_cnt < HCW'(HFP + HPULSE));
    assign o_vsync     = (r_v_cnt >= VCW'(VFP)) && (r_v_cnt < VCW'(VFP + VPULSE));
    assign o_active    = w_h_active && w_v_active;
    assign o_first     = (r_h_cnt == HCW'(HSTART)) && (r_v_cnt == VCW'(VSTART));
    assign o_frame_end = w_h_last && w_v_last;
    assign o_x         = XW'(r_h_cnt - HCW'(HSTART));
    assign o_y         = YW'(r_v_cnt - VCW'(VSTART));

endmodule

// File: rtl/video_timing_stream.sv
// Programmable video timing generator with a valid/ready pixel sink.
// Display starts and stops only on frame boundaries; missing pixels in the
// active area are counted as underflows. Build option VTS_TEST_PATTERN_EN adds
// a grid fill for underflowed pixels and a pattern_force input.
module video_timing_stream
    import video_timing_pkg::*;
#(
    parameter int HDISP  = 800,
    parameter int VDISP  = 480,
    parameter int HFP    = 40,
    parameter int HPULSE = 48,
    parameter int HBP    = 40,
    parameter int VFP    = 12,
    parameter int VPULSE = 3,
    parameter int VBP    = 40,
    parameter int DATA_W = 24,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0,
    parameter int UCNT_W = 16,
    localparam int XW    = cnt_w(HDISP),
    localparam int YW    = cnt_w(VDISP)
) (
    input  logic              pixel_clk,
    input  logic              pixel_rst_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              pix_valid,
    output logic              pix_ready,
`ifdef VTS_TEST_PATTERN_EN
    input  logic              pattern_force,
`endif
    output logic              HS,
    output logic              VS,
    output logic              BLANK,
    output logic [DATA_W-1:0] RGB,
    output logic [XW-1:0]     x,
    output logic [YW-1:0]     y,
    output logic              sof,
    output logic              running,
    output logic [UCNT_W-1:0] underflow_cnt,
    input  logic              ucnt_clr,
    output fsm_e              dbg_state
);

    if (HFP == 0 || HPULSE == 0 || HBP == 0 || VFP == 0 || VPULSE == 0 || VBP == 0) begin : g_bad_timing
        $error("video_timing_stream: porch and sync widths must all be non-zero");
    end

    fsm_e              r_state;
    fsm_e              w_state_next;
    logic              w_hsync;
    logic              w_vsync;
    logic              w_active;
    logic              w_first;
    logic              w_frame_end;
    logic [XW-1:0]     w_x;
    logic [YW-1:0]     w_y;
    logic              w_force;
    logic              w_slot;
    logic              w_underflow;
    logic [DATA_W-1:0] w_fill;
    logic [DATA_W-1:0] w_force_pix;

    logic              r_hs;
    logic              r_vs;
    logic              r_blank;
    logic [DATA_W-1:0] r_rgb;
    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic              r_sof;
    logic              r_running;
    logic [UCNT_W-1:0] r_ucnt;

    video_timing_counter #(
        .HDISP  (HDISP),
        .VDISP  (VDISP),
        .HFP    (HFP),
        .HPULSE (HPULSE),
        .HBP    (HBP),
        .VFP    (VFP),
        .VPULSE (VPULSE),
        .VBP    (VBP)
    ) u_counter (
        .i_clk       (pixel_clk),
        .i_rst_n     (pixel_rst_n),
        .o_hsync     (w_hsync),
        .o_vsync     (w_vsync),
        .o_active    (w_active),
        .o_first     (w_first),
        .o_frame_end (w_frame_end),
        .o_x         (w_x),
        .o_y         (w_y)
    );

`ifdef VTS_TEST_PATTERN_EN
    assign w_force     = pattern_force;
    assign w_force_pix = grid_on(int'(w_x), int'(w_y)) ? DATA_W'(RGB_WHITE) : DATA_W'(RGB_BLACK);
    assign w_fill      = w_force_pix;
`else
    assign w_force     = 1'b0;
    assign w_force_pix = DATA_W'(RGB_BLACK);
    assign w_fill      = DATA_W'(RGB_BLACK);
`endif

    // Handshake: a pixel is consumed in exactly the cycles where pix_valid and
    // pix_ready are both 1. pix_ready depends only on state and raster position
    // (never on pix_valid). A ready cycle without pix_valid is an underflow:
    // that pixel slot is lost, and upstream is not asked to realign.
    assign w_slot      = (r_state != IDLE) && w_active && !w_force;
    assign w_underflow = w_slot && !pix_valid;

    // State register.
    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and sink ready; enable is only honoured at the frame boundary,
    // and a frame that has started always runs to its end.
    always_comb begin
        w_state_next = r_state;
        pix_ready    = w_slot;
        case (r_state)
            IDLE:    if (enable && w_frame_end) w_state_next = RUN;
            RUN:     if (!enable) w_state_next = w_frame_end ? IDLE : DRAIN;
            DRAIN:   if (w_frame_end) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Registered timing, coordinate and status outputs.
    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            r_hs      <= ~HS_POL;
            r_vs      <= ~VS_POL;
            r_blank   <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_sof     <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_hs      <= w_hsync ? HS_POL : ~HS_POL;
            r_vs      <= w_vsync ? VS_POL : ~VS_POL;
            r_blank   <= w_active;
            r_x       <= w_active ? w_x : '0;
            r_y       <= w_active ? w_y : '0;
            r_sof     <= (r_state == RUN) && w_first;
            r_running <= (r_state == RUN);
        end
    end

    // Displayed pixel: upstream data, fill on underflow, black elsewhere.
    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            r_rgb <= '0;
        end else if (w_slot) begin
            r_rgb <= pix_valid ? pix_data : w_fill;
        end else if (w_force && w_active) begin
            r_rgb <= w_force_pix;
        end else begin
            r_rgb <= '0;
        end
    end

    // Saturating underflow counter; clear wins over a same-cycle increment.
    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            r_ucnt <= '0;
        end else if (ucnt_clr) begin
            r_ucnt <= '0;
        end else if (w_underflow && (r_ucnt != '1)) begin
            r_ucnt <= r_ucnt + UCNT_W'(1);
        end
    end

    assign HS            = r_hs;
    assign VS            = r_vs;
    assign BLANK         = r_blank;
    assign RGB           = r_rgb;
    assign x             = r_x;
    assign y             = r_y;
    assign sof           = r_sof;
    assign running       = r_running;
    assign underflow_cnt = r_ucnt;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_video_timing_stream.sv
// Directed bench for video_timing_stream on a tiny 13x7 raster.
// A cycle-level reference of the raster and stream state predicts every
// registered output; displayed pixels go through an expected queue.
module tb_video_timing_stream;
    import video_timing_pkg::*;

    localparam int HDISP  = 8;
    localparam int VDISP  = 4;
    localparam int HFP    = 2;
    localparam int HPULSE = 1;
    localparam int HBP    = 2;
    localparam int VFP    = 1;
    localparam int VPULSE = 1;
    localparam int VBP    = 1;
    localparam int DATA_W = 24;
    localparam int UCNT_W = 3;
    localparam int HTOT   = 13;
    localparam int VTOT   = 7;
    localparam int HST    = 5;
    localparam int VST    = 3;
    localparam int FRAME  = HTOT * VTOT;

    // Clock and reset.
    logic              pixel_clk = 1'b0;
    logic              pixel_rst_n;
    always #5 pixel_clk = ~pixel_clk;

    logic              enable;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              HS;
    logic              VS;
    logic              BLANK;
    logic [DATA_W-1:0] RGB;
    logic [2:0]        x;
    logic [1:0]        y;
    logic              sof;
    logic              running;
    logic [UCNT_W-1:0] underflow_cnt;
    logic              ucnt_clr;
    fsm_e              dbg_state;
`ifdef VTS_TEST_PATTERN_EN
    logic              pattern_force;
`endif

    video_timing_stream #(
        .HDISP (HDISP), .VDISP (VDISP), .HFP (HFP), .HPULSE (HPULSE), .HBP (HBP),
        .VFP (VFP), .VPULSE (VPULSE), .VBP (VBP), .DATA_W (DATA_W),
        .HS_POL (1'b0), .VS_POL (1'b0), .UCNT_W (UCNT_W)
    ) dut (
        .pixel_clk     (pixel_clk),
        .pixel_rst_n   (pixel_rst_n),
        .enable        (enable),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
`ifdef VTS_TEST_PATTERN_EN
        .pattern_force (pattern_force),
`endif
        .HS            (HS),
        .VS            (VS),
        .BLANK         (BLANK),
        .RGB           (RGB),
        .x             (x),
        .y             (y),
        .sof           (sof),
        .running       (running),
        .underflow_cnt (underflow_cnt),
        .ucnt_clr      (ucnt_clr),
        .dbg_state     (dbg_state)
    );

    // Scoreboard and reference state.
    logic [DATA_W-1:0] exp_q[$];
    int                n_checks = 0;
    int                n_errors = 0;
    int                m_h;
    int                m_v;
    fsm_e              m_st;
    logic [UCNT_W-1:0] m_ucnt;
    int                pix_idx;
    int                hs_low_cnt;
    int                ready_cnt;
    int                hshake_cnt;
    int                sof_cnt;
    logic [DATA_W-1:0] last_rgb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_checks++;
        n_errors++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    function automatic logic [DATA_W-1:0] grid_pix(input int px, input int py);
        return (((px % 16) == 0) || ((py % 16) == 0)) ? 24'hFFFFFF : 24'h000000;
    endfunction

    // Driver + reference for one clock: called at a falling edge with inputs set.
    task automatic cycle();
        logic              act;
        logic              slot;
        logic              force_now;
        logic              was_idle;
        logic              e_hs;
        logic              e_vs;
        logic              e_blank;
        logic              e_sof;
        logic              e_run;
        int                e_x;
        int                e_y;
        logic [DATA_W-1:0] fill;
        logic [DATA_W-1:0] e_rgb;

        force_now = 1'b0;
`ifdef VTS_TEST_PATTERN_EN
        force_now = pattern_force;
`endif
        pix_data = DATA_W'(pix_idx);
        act      = (m_h >= HST) && (m_v >= VST);
        slot     = (m_st != IDLE) && act && !force_now;
        check("pix_ready", pix_ready, slot);
        if (pix_ready) begin
            ready_cnt++;
            pix_idx = (pix_idx + 1) % 32;
        end
        if (pix_ready && pix_valid) hshake_cnt++;

        e_hs     = !((m_h >= HFP) && (m_h < HFP + HPULSE));
        e_vs     = !((m_v >= VFP) && (m_v < VFP + VPULSE));
        e_blank  = act;
        e_x      = m_h - HST;
        e_y      = m_v - VST;
        e_sof    = (m_st == RUN) && (m_h == HST) && (m_v == VST);
        e_run    = (m_st == RUN);
        was_idle = (m_st == IDLE);

        fill = '0;
`ifdef VTS_TEST_PATTERN_EN
        fill = grid_pix(e_x, e_y);
`endif
        if (act) begin
            if (force_now) exp_q.push_back(grid_pix(e_x, e_y));
            else if (slot) exp_q.push_back(pix_valid ? pix_data : fill);
            else exp_q.push_back('0);
        end

        if (ucnt_clr) m_ucnt = '0;
        else if (slot && !pix_valid && (m_ucnt != '1)) m_ucnt = m_ucnt + 1'b1;

        if ((m_h == HTOT - 1) && (m_v == VTOT - 1)) begin
            if (m_st == IDLE && enable) m_st = RUN;
            else if (m_st != IDLE && !(m_st == RUN && enable)) m_st = IDLE;
        end else if (m_st == RUN && !enable) begin
            m_st = DRAIN;
        end
        if (m_h == HTOT - 1) begin
            m_h = 0;
            m_v = (m_v == VTOT - 1) ? 0 : m_v + 1;
        end else begin
            m_h = m_h + 1;
        end

        @(negedge pixel_clk);
        check("HS", HS, e_hs);
        check("VS", VS, e_vs);
        check("BLANK", BLANK, e_blank);
        check("sof", sof, e_sof);
        check("running", running, e_run);
        check("underflow_cnt", underflow_cnt, m_ucnt);
        check("state", dbg_state, m_st);
        if (e_blank) begin
            if (exp_q.size() == 0) begin
                timeout("rgb_queue_empty");
            end else begin
                e_rgb = exp_q.pop_front();
                check("RGB", RGB, e_rgb);
            end
            check("x", x, e_x);
            check("y", y, e_y);
            last_rgb = RGB;
        end else if (was_idle) begin
            check("RGB_idle", RGB, 0);
        end
        if (HS == 1'b0) hs_low_cnt++;
        if (sof) sof_cnt++;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Advance at least one cycle, then stop at raster position (0,0).
    task automatic run_until_frame_start();
        int guard;
        guard = 0;
        do begin
            cycle();
            guard++;
        end while (!(m_h == 0 && m_v == 0) && guard < 2 * FRAME);
        if (!(m_h == 0 && m_v == 0)) timeout("frame_start_wait");
    endtask

    task automatic run_to(input int h, input int v);
        int guard;
        guard = 0;
        while (!(m_h == h && m_v == v) && guard < 2 * FRAME) begin
            cycle();
            guard++;
        end
        if (!(m_h == h && m_v == v)) timeout("position_wait");
    endtask

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (!pix_ready && guard < 2 * FRAME) begin
            cycle();
            guard++;
        end
        if (!pix_ready) timeout("pix_ready_wait");
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_HS"}, HS, 1'b1);
        check({tag, "_VS"}, VS, 1'b1);
        check({tag, "_BLANK"}, BLANK, 1'b0);
        check({tag, "_RGB"}, RGB, 0);
        check({tag, "_x"}, x, 0);
        check({tag, "_y"}, y, 0);
        check({tag, "_sof"}, sof, 1'b0);
        check({tag, "_running"}, running, 1'b0);
        check({tag, "_ucnt"}, underflow_cnt, 0);
        check({tag, "_pix_ready"}, pix_ready, 1'b0);
        check({tag, "_state"}, dbg_state, IDLE);
    endtask

    task automatic model_reset();
        m_h     = 0;
        m_v     = 0;
        m_st    = IDLE;
        m_ucnt  = '0;
        pix_idx = 0;
        exp_q.delete();
    endtask

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pixel_rst_n = 1'b0;
        enable      = 1'b0;
        pix_valid   = 1'b1;
        pix_data    = '0;
        ucnt_clr    = 1'b0;
        last_rgb    = '0;
`ifdef VTS_TEST_PATTERN_EN
        pattern_force = 1'b0;
`endif
        model_reset();
        repeat (3) @(negedge pixel_clk);
        check_reset_values("reset");
        pixel_rst_n = 1'b1;

        // Two frames with display off.
        hs_low_cnt = 0; ready_cnt = 0; sof_cnt = 0;
        run_cycles(2 * FRAME);
        check("idle_hs_low", hs_low_cnt, 2 * VTOT);
        check("idle_ready", ready_cnt, 0);
        check("idle_sof", sof_cnt, 0);

        // Enable mid-frame; display starts at the next boundary.
        run_cycles(40);
        enable = 1'b1;
        run_until_frame_start();
        check("start_state", dbg_state, RUN);
        pix_idx = 0; hshake_cnt = 0; sof_cnt = 0;
        run_cycles(FRAME);
        check("frame_handshakes", hshake_cnt, 32);
        check("frame_sof", sof_cnt, 1);
        check("frame_last_rgb", last_rgb, 31);

        // Three underflowed slots: counted, shown black, no shift afterwards.
        hshake_cnt = 0;
        repeat (3) begin
            wait_ready();
            pix_valid = 1'b0;
            cycle();
            pix_valid = 1'b1;
        end
        run_until_frame_start();
        check("underflow_cnt_3", underflow_cnt, 3);
        check("underflow_handshakes", hshake_cnt, 29);

        // Drop enable at y=1: the frame still completes.
        hshake_cnt = 0;
        run_to(HST + 2, VST + 1);
        enable = 1'b0;
        run_until_frame_start();
        check("drop_handshakes", hshake_cnt, 32);
        check("drop_state", dbg_state, IDLE);
        ready_cnt = 0;
        run_cycles(FRAME);
        check("post_drop_ready", ready_cnt, 0);

        // Saturation, then clear racing an increment.
        enable = 1'b1;
        pix_valid = 1'b0;
        run_until_frame_start();
        run_until_frame_start();
        check("ucnt_saturated", underflow_cnt, 7);
        wait_ready();
        ucnt_clr = 1'b1;
        cycle();
        ucnt_clr = 1'b0;
        check("ucnt_clr_priority", underflow_cnt, 0);
        run_until_frame_start();
        check("ucnt_resaturated", underflow_cnt, 7);

        // Asynchronous reset in the middle of an active line.
        pix_valid = 1'b1;
        wait_ready();
        run_cycles(2);
        check("pre_reset_blank", BLANK, 1'b1);
        pixel_rst_n = 1'b0;
        #1;
        check_reset_values("midline_reset");
        model_reset();
        @(negedge pixel_clk);
        pixel_rst_n = 1'b1;
        run_until_frame_start();
        hshake_cnt = 0;
        run_until_frame_start();
        check("post_reset_handshakes", hshake_cnt, 32);

`ifdef VTS_TEST_PATTERN_EN
        // Forced grid: no pixels pulled, grid drawn on the active area.
        pattern_force = 1'b1;
        ready_cnt = 0;
        run_until_frame_start();
        check("force_ready", ready_cnt, 0);
        pattern_force = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
